// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the decode stage and the hazard scoreboard:
// ID-stage issue request, flush, and the stall/forward/busy/counter results.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LAT_W    = 2,
    parameter int unsigned CNT_W    = 16
);
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic                issue_regwrite;
    logic [LAT_W-1:0]    issue_lat;
    logic [ADDR_W-1:0]   issue_rs1;
    logic [ADDR_W-1:0]   issue_rs2;
    logic                issue_use_rs1;
    logic                issue_use_rs2;
    logic                flush;
    logic                stall;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic [NUM_REGS-1:0] busy_vec;
    logic [CNT_W-1:0]    stall_cycles;

    modport master (
        output issue_valid, issue_rd, issue_regwrite, issue_lat,
        output issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2, flush,
        input  stall, fwd_a, fwd_b, busy_vec, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rd, issue_regwrite, issue_lat,
        input  issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2, flush,
        output stall, fwd_a, fwd_b, busy_vec, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker for a 5-stage pipeline: detects load-use
// hazards (stall), selects EX/MEM or MEM/WB forwarding, and counts stall cycles.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned WB_AGE   = 3,
    parameter int unsigned LAT_W    = 2,
    parameter int unsigned CNT_W    = 16
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave sb
);
    localparam int unsigned      AGE_W   = $clog2(WB_AGE + 1);
    localparam logic [LAT_W-1:0] MAX_LAT = LAT_W'(WB_AGE - 1);

    logic [NUM_REGS-1:0]            valid_q, valid_d;
    logic [NUM_REGS-1:0][AGE_W-1:0] age_q, age_d;
    logic [NUM_REGS-1:0][LAT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic             hit_a, hit_b, stall, accept, wr_en;
    logic [LAT_W-1:0] lat_c, remain_new;

    // Forwarding only applies once the producer's result exists (remain == 0).
    function automatic logic [1:0] fwd_sel(input logic hit, input logic [AGE_W-1:0] age,
                                           input logic [LAT_W-1:0] remain);
        if (!hit || remain != '0) return 2'b00;
        if (age == AGE_W'(1)) return 2'b10;
        if (age == AGE_W'(2)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        hit_a = sb.issue_use_rs1 && (sb.issue_rs1 != '0) && valid_q[sb.issue_rs1];
        hit_b = sb.issue_use_rs2 && (sb.issue_rs2 != '0) && valid_q[sb.issue_rs2];
        stall = sb.issue_valid && !sb.flush &&
                ((hit_a && remain_q[sb.issue_rs1] != '0) ||
                 (hit_b && remain_q[sb.issue_rs2] != '0));
        accept     = sb.issue_valid && !stall && !sb.flush;
        wr_en      = accept && sb.issue_regwrite && (sb.issue_rd != '0);
        lat_c      = (sb.issue_lat > MAX_LAT) ? MAX_LAT : sb.issue_lat;
        remain_new = (lat_c == '0) ? '0 : lat_c - LAT_W'(1);
    end

    assign sb.stall        = stall;
    assign sb.fwd_a        = fwd_sel(hit_a, age_q[sb.issue_rs1], remain_q[sb.issue_rs1]);
    assign sb.fwd_b        = fwd_sel(hit_b, age_q[sb.issue_rs2], remain_q[sb.issue_rs2]);
    assign sb.busy_vec     = {valid_q[NUM_REGS-1:1], 1'b0};
    assign sb.stall_cycles = cnt_q;

    always_comb begin
        valid_d  = valid_q;
        age_d    = age_q;
        remain_d = remain_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_en && sb.issue_rd == ADDR_W'(i)) begin
                // Newest producer replaces any older in-flight write (WAW).
                valid_d[i]  = 1'b1;
                age_d[i]    = AGE_W'(1);
                remain_d[i] = remain_new;
            end else if (valid_q[i]) begin
                if ((sb.flush && age_q[i] <= AGE_W'(1)) ||
                    (int'(age_q[i]) + 1 >= int'(WB_AGE))) begin
                    valid_d[i]  = 1'b0;
                    age_d[i]    = '0;
                    remain_d[i] = '0;
                end else begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                    if (remain_q[i] != '0) remain_d[i] = remain_q[i] - LAT_W'(1);
                end
            end
        end
        valid_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            age_q    <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            age_q    <= age_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: a reference scoreboard model predicts outputs each cycle into a
// queue; predictions are popped and compared at the sample point, plus directed checks.
module tb_hazard_scoreboard;
    localparam int unsigned NR = 32;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic          stall;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic [NR-1:0] busy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(NR), .ADDR_W(5), .LAT_W(2), .CNT_W(CW)) bif ();

    hazard_scoreboard #(
        .NUM_REGS(NR), .ADDR_W(5), .WB_AGE(3), .LAT_W(2), .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    exp_t s;  // last sampled DUT outputs

    bit m_valid[NR];
    int m_age[NR];
    int m_rem[NR];
    int m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input bit hit, input int r);
        if (!hit || m_rem[r] != 0) return 2'b00;
        if (m_age[r] == 1) return 2'b10;
        if (m_age[r] == 2) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        bit h1, h2;
        int r1, r2;
        r1 = int'(bif.issue_rs1);
        r2 = int'(bif.issue_rs2);
        h1 = bif.issue_use_rs1 && r1 != 0 && m_valid[r1];
        h2 = bif.issue_use_rs2 && r2 != 0 && m_valid[r2];
        e.stall = bif.issue_valid && !bif.flush && ((h1 && m_rem[r1] > 0) || (h2 && m_rem[r2] > 0));
        e.fa = m_fwd(h1, r1);
        e.fb = m_fwd(h2, r2);
        for (int i = 0; i < NR; i++) e.busy[i] = (i != 0) && m_valid[i];
        e.cnt = CW'(m_cnt);
        return e;
    endfunction

    task automatic model_step(input logic st);
        bit wr;
        int rd, lat;
        rd  = int'(bif.issue_rd);
        wr  = bif.issue_valid && !st && !bif.flush && bif.issue_regwrite && rd != 0;
        lat = int'(bif.issue_lat);
        if (lat > 2) lat = 2;
        if (lat < 1) lat = 1;
        for (int r = 1; r < NR; r++) begin
            if (wr && r == rd) begin
                m_valid[r] = 1; m_age[r] = 1; m_rem[r] = lat - 1;
            end else if (m_valid[r]) begin
                if ((bif.flush && m_age[r] <= 1) || m_age[r] + 1 >= 3) m_valid[r] = 0;
                else begin
                    m_age[r]++;
                    if (m_rem[r] > 0) m_rem[r]--;
                end
            end
        end
        if (st && m_cnt < 15) m_cnt++;
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_valid[r] = 0; m_age[r] = 0; m_rem[r] = 0;
        end
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] lat,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic fl);
        bif.issue_valid = v;   bif.issue_rd = rd;       bif.issue_regwrite = rw;
        bif.issue_lat = lat;   bif.issue_rs1 = rs1;     bif.issue_use_rs1 = u1;
        bif.issue_rs2 = rs2;   bif.issue_use_rs2 = u2;  bif.flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // One cycle with inputs already driven: predict, sample, compare, clock, advance model.
    task automatic cycle();
        exp_t e;
        exp_q.push_back(model_eval());
        @(negedge clk);
        s = '{bif.stall, bif.fwd_a, bif.fwd_b, bif.busy_vec, bif.stall_cycles};
        e = exp_q.pop_front();
        check_eq("model", 64'(s), 64'(e));
        @(posedge clk);
        model_step(e.stall);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        // Outputs during reset, with a would-be reader present.
        drive(1'b1, 5'd3, 1'b1, 2'd2, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("rst_stall", 64'(bif.stall), 64'd0);
        check_eq("rst_fwd", 64'({bif.fwd_a, bif.fwd_b}), 64'd0);
        check_eq("rst_busy", 64'(bif.busy_vec), 64'd0);
        check_eq("rst_cnt", 64'(bif.stall_cycles), 64'd0);
        do_reset();

        // Back-to-back ALU on x5.
        drive(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); cycle();
        check_eq("alu_stall", 64'(s.stall), 64'd0);
        check_eq("alu_fwd_a", 64'(s.fa), 64'h2);
        drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); cycle();
        check_eq("alu_fwd_b", 64'(s.fb), 64'h1);
        drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0); cycle();
        check_eq("alu_fwd_rf", 64'({s.fa, s.fb}), 64'd0);
        check_eq("alu_busy5", 64'(s.busy[5]), 64'd0);

        // Load-use on x6.
        do_reset();
        drive(1'b1, 5'd6, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0); cycle();
        check_eq("lu_stall", 64'(s.stall), 64'd1);
        cycle();
        check_eq("lu_release", 64'(s.stall), 64'd0);
        check_eq("lu_fwd_a", 64'(s.fa), 64'h1);
        idle(); cycle();
        check_eq("lu_cnt", 64'(s.cnt), 64'd1);

        // x0 is never tracked; WAW newest producer wins.
        drive(1'b1, 5'd0, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); cycle();
        check_eq("x0_out", 64'({s.stall, s.fa, s.fb}), 64'd0);
        drive(1'b1, 5'd7, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0); cycle();
        check_eq("waw_stall", 64'(s.stall), 64'd0);
        check_eq("waw_fwd_a", 64'(s.fa), 64'h2);

        // Flush kills the young load and its reader.
        drive(1'b1, 5'd8, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd9, 1'b1, 2'd1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1); cycle();
        check_eq("fl_stall", 64'(s.stall), 64'd0);
        idle(); cycle();
        check_eq("fl_busy8", 64'(s.busy[8]), 64'd0);
        check_eq("fl_busy9", 64'(s.busy[9]), 64'd0);

        // Saturation: ld x9,0(x9) repeatedly stalls every other cycle.
        do_reset();
        drive(1'b1, 5'd9, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd9, 1'b1, 2'd2, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle();
        idle(); cycle();
        check_eq("sat_cnt", 64'(s.cnt), 64'd15);

        // Asynchronous reset in the middle of a load-use stall.
        do_reset();
        drive(1'b1, 5'd6, 1'b1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
        drive(1'b1, 5'd6, 1'b1, 2'd2, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
        cycle(); cycle();
        @(negedge clk);
        check_eq("ar_pre_stall", 64'(bif.stall), 64'd1);
        check_eq("ar_pre_cnt", 64'(bif.stall_cycles), 64'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("ar_stall", 64'(bif.stall), 64'd0);
        check_eq("ar_busy", 64'(bif.busy_vec), 64'd0);
        check_eq("ar_cnt", 64'(bif.stall_cycles), 64'd0);
        @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0); cycle();
        check_eq("ar_clean", 64'({s.stall, s.fa, s.fb}), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_REGS, 32, architectural registers tracked; register 0 is hardwired zero.
- ADDR_W, 5, register address width, equal to clog2(NUM_REGS).
- WB_AGE, 3, age at which a producer's result is in the register file.
- LAT_W, 2, width of issue_lat.
- CNT_W, 16, width of the stall performance counter.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-high.
- issue_valid, in, 1, the instruction in ID requests issue to EX this cycle.
- issue_rd, in, ADDR_W, destination register.
- issue_regwrite, in, 1, the instruction writes rd.
- issue_lat, in, LAT_W, cycles after issue until the result can be forwarded (1 = ALU, 2 = load).
- issue_rs1 / issue_rs2, in, ADDR_W, source registers.
- issue_use_rs1 / issue_use_rs2, in, 1, the source is actually read.
- flush, in, 1, branch redirect: kill the ID instruction and young in-flight entries.
- stall, out, 1, hold PC and IF/ID, and insert a bubble into ID/EX.
- fwd_a / fwd_b, out, 2, forward select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- busy_vec, out, NUM_REGS, registers with an outstanding write.
- stall_cycles, out, CNT_W, saturating count of stall cycles.

Function
REQ-003 Keep one entry per register (1..NUM_REGS-1) with: valid, age (clog2(WB_AGE+1) bits), remain (LAT_W bits).
REQ-004 An issue is accepted when issue_valid=1, stall=0 and flush=0.
REQ-005 Accepted issue with issue_regwrite=1 and issue_rd!=0:
- set entry[rd]: valid=1, age=1, remain=max(issue_lat,1)-1.
- clamp issue_lat to WB_AGE-1.
REQ-006 Every edge, for every valid entry not being (re)written this cycle:
- age increments by 1; remain decrements by 1, saturating at 0.
- the entry is cleared when its age would reach WB_AGE.
REQ-007 WAW: issue to an rd that already has a valid entry overwrites that entry; the newest producer wins.
REQ-008 Hazard hit for source s: issue_use_s=1, rs!=0, and entry[rs].valid=1.
REQ-009 stall is combinational: issue_valid & ~flush & (hit on rs1 or rs2 with entry.remain>0).
REQ-010 fwd_x is combinational and reflects a hit with remain=0:
- age 1 gives 10; age 2 gives 01; otherwise 00.
- no hit gives 00.
- fwd values are valid regardless of stall.
REQ-011 Registers rs1 and rs2 are evaluated independently. When both name the same register, fwd_a equals fwd_b.
REQ-012 flush=1 means: no issue accepted this cycle, stall forced to 0, and every entry with age <= 1 is cleared at the edge. Older entries age normally.
REQ-013 Simultaneous flush with a hazard: flush takes priority; stall=0 and stall_cycles is not incremented.
REQ-014 stall_cycles increments by 1 on each edge where stall=1 and saturates at 2^CNT_W-1.
REQ-015 busy_vec[i] = entry[i].valid; busy_vec[0] = 0 always.
REQ-016 An issue with issue_valid=0, or issue_regwrite=0, or rd=0 creates no entry; aging still proceeds.

Reset
REQ-017 Asserting reset clears all entries immediately, without waiting for a clock edge.
REQ-018 During reset, outputs read: stall=0, fwd_a=fwd_b=00, busy_vec=0, stall_cycles=0.
REQ-019 Reset asserted mid-stall drops stall within the same cycle. The first edge after reset deasserts starts from an empty state.

Verification
REQ-020 Back-to-back ALU: issue add x5 (lat 1), next cycle issue rs1=x5 -> stall=0, fwd_a=10; one cycle later a rs2=x5 reader -> fwd_b=01; after that -> 00, busy_vec[5]=0.
REQ-021 Load-use: issue ld x6 (lat 2), next issue rs1=x6 -> stall=1 for exactly 1 cycle, then fwd_a=01; stall_cycles=1.
REQ-022 x0 and WAW:
- issue rd=x0, then read x0 -> fwd 00, no stall.
- issue ld x7 then add x7 back-to-back, then read x7 -> fwd_a=10 (add wins), stall=0.
REQ-023 Flush: ld x8 issued; next cycle flush=1 with a reader of x8 -> stall=0, x8 entry cleared, busy_vec[8]=0 next cycle.
REQ-024 Reset mid-operation: during a load-use stall, assert reset asynchronously between edges -> stall=0 and busy_vec=0 before the next edge; stall_cycles=0.
REQ-025 Counter saturation with CNT_W=4: hold a load-use hazard for 20 cycles by re-issuing ld -> stall_cycles stops at 15.
